dump_sm: RTL and testbench
==========================

# dump_sm

Dump state machine for the capture RAMs. On a dump request it walks one channel's circular sample buffer oldest-to-newest, reading each byte through the RAM interface (`dump_en`, `ch_sel`, `read_data`) and handing it to the UART transmitter with a one-byte-at-a-time handshake. It is the read-side counterpart of the capture SM, which writes the RAMs through the same interface.

## Interface
- `DEPTH`, 512: samples per channel RAM; must be a power of two.
- `ADDR_W`, 9: RAM address width, equal to log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `dump_start`  in  1  one-cycle request pulse.
- `dump_chan`  in  2  channel to dump: 00 CH1, 01 CH2, 10 CH3, 11 invalid.
- `start_addr`  in  ADDR_W  address of the oldest sample, sampled with `dump_start`.
- `read_data`  in  8  muxed RAM read data, valid the cycle after `dump_en`.
- `tx_done`  in  1  UART transmitter pulse: the current byte has finished.
- `dump_en`  out  1  RAM read enable; ORed with `cap_en` downstream.
- `addr`  out  ADDR_W  RAM read address.
- `ch_sel`  out  2  RAM data mux select.
- `tx_data`  out  8  byte to transmit.
- `trmt`  out  1  one-cycle transmit strobe.
- `busy`  out  1  high from request accept until done.
- `dump_done`  out  1  one-cycle pulse after the final `tx_done`.
- `dump_err`  out  1  one-cycle pulse when a request with `dump_chan`=11 is rejected.

## Operation
- States: IDLE, READ, LATCH, WAIT_TX.
- IDLE:
  - On `dump_start` with a valid channel, latch `dump_chan` into `ch_sel` and `start_addr` into a base register.
  - Clear the sample counter `cnt` (ADDR_W+1 bits), set `busy`, then go to READ.
  - With `dump_chan`=11, pulse `dump_err` for one cycle and stay in IDLE with `busy` low. No RAM access and no `trmt`.
- READ: `dump_en`=1 and `addr`=base+cnt, taken modulo `DEPTH` (natural ADDR_W wrap). Next state is LATCH.
- LATCH:
  - `dump_en`=0.
  - Register `read_data` into `tx_data` and pulse `trmt` for one cycle.
  - Next state is WAIT_TX.
- WAIT_TX:
  - Hold `tx_data` stable.
  - On `tx_done`: if `cnt`=`DEPTH`-1, pulse `dump_done`, clear `busy` and go to IDLE. Otherwise increment `cnt` and go to READ.
- `ch_sel` holds its latched value until the next accepted request.
- `addr` holds its last value outside READ.
- `dump_start` while `busy` is ignored, with no re-latch.
- `tx_done` is ignored in IDLE, READ and LATCH. A stray `tx_done` arriving together with an IDLE `dump_start` does not advance the dump.
- Exactly `DEPTH` bytes are sent per dump; the byte order is the addresses base, base+1, …, wrapping past `DEPTH`-1 to 0.
- This block never drives a write enable; `we` stays owned by the capture SM.

## Timing
- Reset value of every output is 0: `dump_en`, `addr`, `ch_sel`, `tx_data`, `trmt`, `busy`, `dump_done`, `dump_err`. State resets to IDLE.
- Cycle 0: `dump_start` is sampled.
- Cycle 1: READ (`dump_en` high).
- Cycle 2: LATCH. `trmt` high and `tx_data` valid in the same cycle.
- From each `tx_done` to the next `trmt`: exactly 2 cycles (READ, LATCH).
- `dump_done` is asserted in the cycle after the final `tx_done` is sampled. `busy` falls in that same cycle.
- `rst_n` low mid-dump: on the next edge return to IDLE with all outputs 0. No `dump_done` and no partial resume.

## Structure
- Shared package `dso_pkg`:
  - state enum `dump_state_t`;
  - channel code constants `CH1`=2'b00, `CH2`=2'b01, `CH3`=2'b10;
  - invalid-channel sentinel byte 8'h42 (used by the mux and the bench).
- Single module; no sub-module is warranted. The counter and address adder are inline.

## Test plan
- DEPTH=8, CH2 RAM holding 0x10..0x17, `start_addr`=0, UART model returns `tx_done` 5 cycles after `trmt` -> bytes 0x10..0x17 in order, then one `dump_done`.
- DEPTH=8, `start_addr`=6 -> addresses 6,7,0,1,2,3,4,5 and exactly 8 `trmt` pulses.
- `dump_chan`=11 -> `dump_err` for one cycle, `busy`, `trmt` and `dump_en` stay 0.
- Second `dump_start` mid-dump with a different channel -> ignored; `ch_sel` unchanged and the byte count stays 8.
- `rst_n` low after the 3rd byte -> all outputs 0 the next cycle and no `dump_done`; a fresh dump afterwards completes normally.
- `tx_done` held low for 100 cycles -> `tx_data` stable, no extra `trmt`, `dump_en` stays 0.

Source files
------------

// File: rtl/dso_pkg.sv
// ============================================================================
// dso_pkg : shared types and channel codes for the capture/dump state machines
// Rev 1.0
// ============================================================================
`default_nettype none

package dso_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      LATCH   = 2'd2,
      WAIT_TX = 2'd3
   } dump_state_t;

   localparam logic [1:0] CH1    = 2'b00;
   localparam logic [1:0] CH2    = 2'b01;
   localparam logic [1:0] CH3    = 2'b10;
   localparam logic [1:0] CH_INV = 2'b11;

   // Byte returned by the RAM mux when the invalid channel code is selected.
   localparam logic [7:0] INVALID_BYTE = 8'h42;

endpackage

`default_nettype wire

// File: rtl/dump_sm.sv
// ============================================================================
// dump_sm : walks one channel's circular capture buffer oldest-to-newest and
//           feeds each byte to the UART transmitter.
// Rev 1.0
// ============================================================================
`default_nettype none

module dump_sm
   import dso_pkg::*;
#(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dump_start,
   input  logic [1:0]        dump_chan,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [7:0]        read_data,
   input  logic              tx_done,
   output logic              dump_en,
   output logic [ADDR_W-1:0] addr,
   output logic [1:0]        ch_sel,
   output logic [7:0]        tx_data,
   output logic              trmt,
   output logic              busy,
   output logic              dump_done,
   output logic              dump_err
);

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

   dump_state_t       r_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W:0]   r_cnt;
   logic [7:0]        r_tx_data;
   logic [ADDR_W-1:0] w_next_addr;

   assign w_next_addr = r_base + r_cnt[ADDR_W-1:0] + ADDR_W'(1);

   // RAM data only arrives in LATCH, so the byte is passed through in that
   // cycle (aligned with trmt) and held from the register afterwards.
   assign tx_data = (r_state == LATCH) ? read_data : r_tx_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_base    <= '0;
         r_cnt     <= '0;
         r_tx_data <= '0;
         dump_en   <= 1'b0;
         addr      <= '0;
         ch_sel    <= 2'b00;
         trmt      <= 1'b0;
         busy      <= 1'b0;
         dump_done <= 1'b0;
         dump_err  <= 1'b0;
      end else begin
         trmt      <= 1'b0;
         dump_done <= 1'b0;
         dump_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (dump_start) begin
                  if (dump_chan == CH_INV) begin
                     dump_err <= 1'b1;
                  end else begin
                     ch_sel  <= dump_chan;
                     r_base  <= start_addr;
                     r_cnt   <= '0;
                     busy    <= 1'b1;
                     dump_en <= 1'b1;
                     addr    <= start_addr;
                     r_state <= READ;
                  end
               end
            end
            READ: begin
               dump_en <= 1'b0;
               trmt    <= 1'b1;
               r_state <= LATCH;
            end
            LATCH: begin
               r_tx_data <= read_data;
               r_state   <= WAIT_TX;
            end
            WAIT_TX: begin
               if (tx_done) begin
                  if (r_cnt == LAST_CNT) begin
                     dump_done <= 1'b1;
                     busy      <= 1'b0;
                     r_state   <= IDLE;
                  end else begin
                     r_cnt   <= r_cnt + 1'b1;
                     addr    <= w_next_addr;
                     dump_en <= 1'b1;
                     r_state <= READ;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dump_sm.sv
// ============================================================================
// tb_dump_sm : directed self-checking bench for dump_sm (DEPTH=8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dump_sm;
   import dso_pkg::*;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              dump_start;
   logic [1:0]        dump_chan;
   logic [ADDR_W-1:0] start_addr;
   logic [7:0]        read_data = 8'h00;
   logic              tx_done;
   logic              dump_en;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        ch_sel;
   logic [7:0]        tx_data;
   logic              trmt;
   logic              busy;
   logic              dump_done;
   logic              dump_err;

   logic u_done = 1'b0;
   logic m_done;
   logic uart_en;
   int   ucnt = 0;

   int   total = 0;
   int   bad   = 0;

   logic [7:0] mem [4][DEPTH];
   logic [7:0] bytes_q [$];
   int         addrs_q [$];
   int         trmt_n, done_n, err_n, gap_err, done_lat_err;
   int         cyc = 0;
   int         last_done = -100;

   assign tx_done = u_done | m_done;

   always #5 clk = ~clk;

   dump_sm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dump_start (dump_start),
      .dump_chan  (dump_chan),
      .start_addr (start_addr),
      .read_data  (read_data),
      .tx_done    (tx_done),
      .dump_en    (dump_en),
      .addr       (addr),
      .ch_sel     (ch_sel),
      .tx_data    (tx_data),
      .trmt       (trmt),
      .busy       (busy),
      .dump_done  (dump_done),
      .dump_err   (dump_err)
   );

   // Channel RAMs: CH1 = A0+a, CH2 = 10+a, CH3 = 30+a; synchronous read.
   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         mem[0][a] = 8'hA0 + 8'(a);
         mem[1][a] = 8'h10 + 8'(a);
         mem[2][a] = 8'h30 + 8'(a);
         mem[3][a] = INVALID_BYTE;
      end
   end

   always @(posedge clk)
      if (dump_en) read_data <= (ch_sel == CH_INV) ? INVALID_BYTE : mem[ch_sel][addr];

   // UART: tx_done pulses 5 cycles after the trmt cycle.
   always @(negedge clk) begin
      if (!rst_n || !uart_en) begin
         ucnt   = 0;
         u_done = 1'b0;
      end else if (trmt) begin
         ucnt   = 5;
         u_done = 1'b0;
      end else if (ucnt > 0) begin
         ucnt   = ucnt - 1;
         u_done = (ucnt == 0);
      end else begin
         u_done = 1'b0;
      end
   end

   // Monitor sees the values of the cycle that is just ending.
   always @(posedge clk) begin
      if (!rst_n) last_done = -100;
      if (dump_start && !busy) last_done = -100;
      if (trmt) begin
         bytes_q.push_back(tx_data);
         trmt_n++;
         if (last_done >= 0 && cyc - last_done != 2) gap_err++;
      end
      if (dump_en) addrs_q.push_back(int'(addr));
      if (dump_done) begin
         done_n++;
         if (cyc - last_done != 1) done_lat_err++;
      end
      if (dump_err) err_n++;
      if (tx_done && busy) last_done = cyc;
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      bytes_q.delete();
      addrs_q.delete();
      trmt_n = 0; done_n = 0; err_n = 0; gap_err = 0; done_lat_err = 0;
   endtask

   // Called at a negedge; returns at the negedge of the cycle after the request.
   task automatic start_dump(input logic [1:0] ch, input logic [2:0] sa, input logic stray);
      dump_chan  = ch;
      start_addr = sa;
      dump_start = 1'b1;
      m_done     = stray;
      @(negedge clk);
      dump_start = 1'b0;
      m_done     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!dump_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!dump_done) chk("done_timeout", 32'd0, 32'd1);
      else            chk("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({dump_en, addr, ch_sel, tx_data, trmt, busy, dump_done, dump_err});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int exp_a[8];
      int viol;
      int n;
      logic [7:0] hold;

      rst_n = 1'b0; dump_start = 1'b0; dump_chan = 2'b00; start_addr = '0;
      m_done = 1'b0; uart_en = 1'b1;
      clear_logs();
      repeat (3) @(negedge clk);
      chk("reset_outs", all_outs(), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: CH2 from 0, stray tx_done alongside the request
      clear_logs();
      start_dump(CH2, 3'd0, 1'b1);
      chk("t1_c1_en",    32'(dump_en), 32'd1);
      chk("t1_c1_busy",  32'(busy),    32'd1);
      chk("t1_c1_addr",  32'(addr),    32'd0);
      chk("t1_c1_chsel", 32'(ch_sel),  32'd1);
      @(negedge clk);
      chk("t1_c2_trmt",  32'(trmt),    32'd1);
      chk("t1_c2_data",  32'(tx_data), 32'h10);
      chk("t1_c2_en",    32'(dump_en), 32'd0);
      wait_done(300);
      chk("t1_count", 32'(bytes_q.size()), 32'd8);
      for (int i = 0; i < bytes_q.size(); i++)
         chk("t1_byte", 32'(bytes_q[i]), 32'h10 + 32'(i));
      chk("t1_done_n",   32'(done_n),       32'd1);
      chk("t1_gap",      32'(gap_err),      32'd0);
      chk("t1_done_lat", 32'(done_lat_err), 32'd0);

      // 2: CH1 from 6, wraps
      clear_logs();
      exp_a = '{6, 7, 0, 1, 2, 3, 4, 5};
      start_dump(CH1, 3'd6, 1'b0);
      wait_done(300);
      chk("t2_addr_n", 32'(addrs_q.size()), 32'd8);
      chk("t2_trmt_n", 32'(trmt_n), 32'd8);
      for (int i = 0; i < addrs_q.size() && i < 8; i++)
         chk("t2_addr", 32'(addrs_q[i]), 32'(exp_a[i]));
      for (int i = 0; i < bytes_q.size() && i < 8; i++)
         chk("t2_byte", 32'(bytes_q[i]), 32'hA0 + 32'(exp_a[i]));
      chk("t2_done_n", 32'(done_n), 32'd1);

      // 3: invalid channel
      clear_logs();
      start_dump(CH_INV, 3'd0, 1'b0);
      chk("t3_err",  32'(dump_err), 32'd1);
      chk("t3_busy", 32'(busy),     32'd0);
      viol = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy || trmt || dump_en || dump_err) viol++;
      end
      chk("t3_quiet",  32'(viol),  32'd0);
      chk("t3_err_n",  32'(err_n), 32'd1);
      chk("t3_trmt_n", 32'(trmt_n), 32'd0);
      chk("t3_reads",  32'(addrs_q.size()), 32'd0);

      // 4: second request mid-dump ignored
      clear_logs();
      start_dump(CH3, 3'd2, 1'b0);
      repeat (10) @(negedge clk);
      start_dump(CH1, 3'd5, 1'b0);
      chk("t4_chsel_mid", 32'(ch_sel), 32'd2);
      wait_done(300);
      chk("t4_chsel_end", 32'(ch_sel), 32'd2);
      chk("t4_trmt_n",    32'(trmt_n), 32'd8);
      for (int i = 0; i < bytes_q.size() && i < 8; i++)
         chk("t4_byte", 32'(bytes_q[i]), 32'h30 + 32'((2 + i) % 8));
      chk("t4_done_n", 32'(done_n), 32'd1);

      // 5: reset after the 3rd byte, then a fresh dump
      clear_logs();
      start_dump(CH2, 3'd0, 1'b0);
      n = 0;
      while (trmt_n < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reach3", 32'(trmt_n >= 3), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_rst_outs", all_outs(), 32'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("t5_no_done", 32'(done_n), 32'd0);
      chk("t5_idle",    32'(busy),   32'd0);
      clear_logs();
      start_dump(CH1, 3'd3, 1'b0);
      wait_done(300);
      chk("t5_trmt_n", 32'(trmt_n), 32'd8);
      if (bytes_q.size() == 8) begin
         chk("t5_first", 32'(bytes_q[0]), 32'hA3);
         chk("t5_last",  32'(bytes_q[7]), 32'hA2);
      end
      chk("t5_done_n", 32'(done_n), 32'd1);

      // 6: tx_done withheld for 100 cycles
      clear_logs();
      uart_en = 1'b0;
      start_dump(CH3, 3'd0, 1'b0);
      @(negedge clk);
      chk("t6_trmt", 32'(trmt),    32'd1);
      chk("t6_data", 32'(tx_data), 32'h30);
      hold = tx_data;
      viol = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx_data !== hold || trmt || dump_en) viol++;
      end
      chk("t6_hold", 32'(viol), 32'd0);
      chk("t6_busy", 32'(busy), 32'd1);
      m_done = 1'b1;
      @(negedge clk);
      m_done  = 1'b0;
      uart_en = 1'b1;
      wait_done(300);
      chk("t6_trmt_n", 32'(trmt_n), 32'd8);
      if (bytes_q.size() == 8) chk("t6_last", 32'(bytes_q[7]), 32'h37);
      chk("t6_gap", 32'(gap_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
